bit_unpack_stream: RTL and testbench

Parametrised stream unpacker: it takes packed, LSB-first words of `IN_W` bits and emits one value per output beat.
- Value width is set at run time from 1 to `MAX_BW` bits.
- Each value is zero- or sign-extended to `OUT_W` bits.
- A frame carries a programmed value count; the block marks the last value and discards the trailing pad bits.

It sits between the memory read stream and the number-converter datapath. Relative to the earlier fixed 16-bit extractor, it adds width parameters, a signed mode, frame start/last/done control and exact input-word accounting.

---
 rtl/bit_unpack_stream.sv | 88 ++++++++
 tb/tb_bit_unpack_stream.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_unpack_stream.sv
// bit_unpack_stream: unpacks LSB-first IN_W-bit words into 1..MAX_BW-bit values, zero/sign-extended to OUT_W, framed by start/last/done
module bit_unpack_stream #(
  parameter int IN_W = 16,
  parameter int OUT_W = 16,
  parameter int MAX_BW = 16,
  parameter int CNT_W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(MAX_BW+1)-1:0]  cfg_bitwidth,
  input  logic                         cfg_signed,
  input  logic [CNT_W-1:0]             cfg_count,
  input  logic                         start,
  input  logic                         rcv_valid,
  input  logic [IN_W-1:0]              rcv_data,
  output logic                         rcv_ready,
  output logic                         trm_valid,
  output logic [OUT_W-1:0]             trm_data,
  output logic                         trm_last,
  input  logic                         trm_ready,
  output logic                         busy,
  output logic                         done
);
  localparam int BW_W = $clog2(MAX_BW+1);
  localparam int FW = $clog2(2*IN_W+1);
  localparam int LG = $clog2(IN_W);
  localparam int PW = CNT_W + BW_W;
  localparam logic [BW_W-1:0] MAX_BW_L = BW_W'(MAX_BW);
  localparam logic [FW-1:0] IN_W_L = FW'(IN_W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [BW_W-1:0] bw, bw_in;
  logic sgn;
  logic [CNT_W-1:0] values_left, words_left, words_in;
  logic [PW-1:0] bits_in;
  logic [2*IN_W-1:0] sreg, sreg_nxt;
  logic [FW-1:0] fill, fill_nxt, base;
  logic [MAX_BW-1:0] mask, raw;
  logic acc, emit, last_hs;
  always_comb begin
    bw_in = (cfg_bitwidth == '0 || cfg_bitwidth > MAX_BW_L) ? MAX_BW_L : cfg_bitwidth;
    bits_in = PW'(cfg_count) * PW'(bw_in);
    words_in = CNT_W'(bits_in >> LG) + CNT_W'(|bits_in[LG-1:0]);
    rcv_ready = state == RUN && words_left != '0 && fill <= IN_W_L;
    trm_valid = state == RUN && values_left != '0 && fill >= FW'(bw);
    trm_last = trm_valid && values_left == CNT_W'(1);
    busy = state == RUN;
    done = state == DONE;
    acc = rcv_valid && rcv_ready;
    emit = trm_valid && trm_ready;
    last_hs = emit && values_left == CNT_W'(1);
    mask = ~({MAX_BW{1'b1}} << bw);
    raw = sreg[MAX_BW-1:0] & mask;
    // mask & ~(mask >> 1) isolates the value's top bit without indexing by bw-1
    trm_data = OUT_W'(raw) | ((sgn && |(raw & ~(mask >> 1))) ? {OUT_W{1'b1}} << bw : '0);
    base = emit ? fill - FW'(bw) : fill;
    fill_nxt = base + (acc ? IN_W_L : '0);
    sreg_nxt = (emit ? sreg >> bw : sreg) | (acc ? {{IN_W{1'b0}}, rcv_data} << base : '0);
    state_nxt = state == IDLE ? (start ? (cfg_count == '0 ? DONE : RUN) : IDLE)
              : state == RUN ? (last_hs ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bw <= '0;
      sgn <= 1'b0;
      values_left <= '0;
      words_left <= '0;
      sreg <= '0;
      fill <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        bw <= bw_in;
        sgn <= cfg_signed;
        values_left <= cfg_count;
        words_left <= words_in;
        sreg <= '0;
        fill <= '0;
      end
    end else if (state == RUN) begin
      values_left <= values_left - CNT_W'(emit);
      words_left <= words_left - CNT_W'(acc);
      sreg <= last_hs ? '0 : sreg_nxt;
      fill <= last_hs ? '0 : fill_nxt;
    end
endmodule

// File: tb/tb_bit_unpack_stream.sv
// tb_bit_unpack_stream: randomized and directed checks of bit_unpack_stream against a bit-stream reference model
module tb_bit_unpack_stream;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] cfg_bitwidth;
  logic cfg_signed;
  logic [31:0] cfg_count;
  logic start, rcv_valid, rcv_ready, trm_valid, trm_last, trm_ready, busy, done;
  logic [15:0] rcv_data, trm_data;
  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] in_words[$];
  logic [15:0] got_q[$];
  logic [15:0] exp_q[$];
  int used, viol, timed_out;

  bit_unpack_stream dut (
    .clk(clk), .rst(rst), .cfg_bitwidth(cfg_bitwidth), .cfg_signed(cfg_signed),
    .cfg_count(cfg_count), .start(start), .rcv_valid(rcv_valid), .rcv_data(rcv_data),
    .rcv_ready(rcv_ready), .trm_valid(trm_valid), .trm_data(trm_data), .trm_last(trm_last),
    .trm_ready(trm_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic model(input int bwe, input bit sg, input int cnt);
    exp_q.delete();
    for (int i = 0; i < cnt; i++) begin
      int v = 0;
      for (int b = 0; b < bwe; b++) begin
        int pos = i * bwe + b;
        if (in_words[pos / 16][pos % 16]) v += 1 << b;
      end
      if (sg && v >= (1 << (bwe - 1))) v -= 1 << bwe;
      exp_q.push_back(16'(v));
    end
  endtask

  task automatic run_frame(input int bwc, input bit sg, input int cnt, input int rdy_pct, input int vld_pct,
                           input logic [31:0] rdy_off, input logic [31:0] vld_off, input int start_at);
    int bwe, needed, nemit, fill_m;
    bit prev_hold, rv, tr, e_rr, e_tv, e_tl;
    logic rr, tv, tl, dn, bz;
    logic [15:0] td, prev_td;
    logic prev_tl;
    bwe = (bwc == 0 || bwc > 16) ? 16 : bwc;
    needed = (cnt * bwe + 15) / 16;
    got_q.delete();
    used = 0;
    viol = 0;
    timed_out = 0;
    nemit = 0;
    prev_hold = 0;
    prev_td = '0;
    prev_tl = 1'b0;
    @(negedge clk);
    cfg_bitwidth = 5'(bwc);
    cfg_signed = sg;
    cfg_count = 32'(cnt);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; ; c++) begin
      if (c >= 1000) begin
        timed_out = 1;
        break;
      end
      rr = rcv_ready; tv = trm_valid; tl = trm_last; td = trm_data; dn = done; bz = busy;
      fill_m = used * 16 - nemit * bwe;
      e_rr = used < needed && fill_m <= 16;
      e_tv = nemit < cnt && fill_m >= bwe;
      e_tl = e_tv && nemit == cnt - 1;
      if ((prev_hold && (tv !== 1'b1 || td !== prev_td || tl !== prev_tl)) || rr !== e_rr || tv !== e_tv ||
          tl !== e_tl || bz !== (nemit < cnt) || dn !== (nemit == cnt)) begin
        viol++;
        if (viol < 5)
          $display("protocol violation cycle %0d: rdy=%b/%b vld=%b/%b last=%b/%b busy=%b done=%b data=%h held=%h",
                   c, rr, e_rr, tv, e_tv, tl, e_tl, bz, dn, td, prev_td);
      end
      if (dn === 1'b1) break;
      if (c == start_at) begin
        cfg_bitwidth = 5'd8;
        cfg_count = 32'd2;
        start = 1'b1;
      end else start = 1'b0;
      rv = !((c < 32) ? vld_off[c] : 1'b0) && $urandom_range(99) < 32'(vld_pct);
      tr = !((c < 32) ? rdy_off[c] : 1'b0) && $urandom_range(99) < 32'(rdy_pct);
      rcv_valid = rv;
      rcv_data = used < in_words.size() ? in_words[used] : 16'($urandom);
      trm_ready = tr;
      if (rr && rv) used++;
      if (tv && tr) begin
        got_q.push_back(td);
        nemit++;
      end
      prev_hold = tv && !tr;
      prev_td = td;
      prev_tl = tl;
      @(negedge clk);
    end
    rcv_valid = 1'b0;
    trm_ready = 1'b0;
    start = 1'b0;
    @(negedge clk);
    if (done !== 1'b0 || busy !== 1'b0 || rcv_ready !== 1'b0 || trm_valid !== 1'b0) begin
      viol++;
      $display("protocol violation after done: done=%b busy=%b rdy=%b vld=%b", done, busy, rcv_ready, trm_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++; if (rcv_ready !== 1'b0) begin n_fail++; $display("FAIL reset_rcv_ready: got %b want 0", rcv_ready); end
    n_chk++; if (trm_valid !== 1'b0) begin n_fail++; $display("FAIL reset_trm_valid: got %b want 0", trm_valid); end
    n_chk++; if (trm_last !== 1'b0) begin n_fail++; $display("FAIL reset_trm_last: got %b want 0", trm_last); end
    n_chk++; if (trm_data !== 16'h0) begin n_fail++; $display("FAIL reset_trm_data: got %h want 0000", trm_data); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || rcv_ready !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b rdy=%b want 0 0", busy, rcv_ready); end
  endtask

  task automatic test_basic();
    in_words = '{16'h4321, 16'h8765, 16'hFFFF};
    run_frame(4, 0, 8, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0) begin n_fail++; $display("FAIL basic_protocol: violations=%0d timeout=%0d want 0 0", viol, timed_out); end
    n_chk++; if (used !== 2) begin n_fail++; $display("FAIL basic_words: got %0d want 2", used); end
    n_chk++; if (got_q.size() !== 8) begin n_fail++; $display("FAIL basic_count: got %0d want 8", got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_chk++; if (got_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL basic_value[%0d]: got %h want %h", i, got_q[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_straddle_signed();
    logic [15:0] es[4] = '{16'h0321, 16'h0654, 16'hF987, 16'hFCBA};
    logic [15:0] eu[4] = '{16'h0321, 16'h0654, 16'h0987, 16'h0CBA};
    for (int m = 0; m < 2; m++) begin
      in_words = '{16'h4321, 16'h8765, 16'hCBA9, 16'h1111};
      run_frame(12, m == 0, 4, 100, 100, 0, 0, -1);
      n_chk++; if (viol !== 0 || timed_out !== 0) begin n_fail++; $display("FAIL straddle%0d_protocol: violations=%0d timeout=%0d want 0 0", m, viol, timed_out); end
      n_chk++; if (used !== 3 || got_q.size() !== 4) begin n_fail++; $display("FAIL straddle%0d_counts: words %0d values %0d want 3 4", m, used, got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
        n_chk++; if (got_q[i] !== (m == 0 ? es[i] : eu[i])) begin n_fail++; $display("FAIL straddle%0d_value[%0d]: got %h want %h", m, i, got_q[i], m == 0 ? es[i] : eu[i]); end
      end
    end
  endtask

  task automatic test_pad_discard();
    logic [15:0] e1[3] = '{16'd1, 16'd25, 16'd16};
    in_words = '{16'h4321, 16'h8765};
    run_frame(5, 0, 3, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 1 || got_q.size() !== 3) begin n_fail++; $display("FAIL pad1_frame: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 1 3", viol, timed_out, used, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_chk++; if (got_q[i] !== e1[i]) begin n_fail++; $display("FAIL pad1_value[%0d]: got %h want %h", i, got_q[i], e1[i]); end
    end
    in_words = '{16'h8765, 16'h0000};
    run_frame(4, 0, 4, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 1 || got_q.size() !== 4) begin n_fail++; $display("FAIL pad2_frame: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 1 4", viol, timed_out, used, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      n_chk++; if (got_q[i] !== 16'(i + 5)) begin n_fail++; $display("FAIL pad2_value[%0d]: got %h want %h", i, got_q[i], 16'(i + 5)); end
    end
  endtask

  task automatic test_backpressure();
    in_words = '{16'h4321, 16'h8765, 16'hCBA9, 16'h0000};
    run_frame(4, 0, 12, 100, 100, 32'h0000_003C, 32'h0000_01E0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0) begin n_fail++; $display("FAIL backpressure_protocol: violations=%0d timeout=%0d want 0 0", viol, timed_out); end
    n_chk++; if (used !== 3 || got_q.size() !== 12) begin n_fail++; $display("FAIL backpressure_counts: words %0d values %0d want 3 12", used, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      n_chk++; if (got_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL backpressure_value[%0d]: got %h want %h", i, got_q[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_edge();
    in_words = '{16'h1234};
    run_frame(4, 0, 0, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 0 || got_q.size() !== 0) begin n_fail++; $display("FAIL count0: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 0 0", viol, timed_out, used, got_q.size()); end
    in_words = '{16'h4321, 16'h9999};
    run_frame(0, 0, 1, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 1 || got_q.size() !== 1) begin n_fail++; $display("FAIL bw0_frame: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 1 1", viol, timed_out, used, got_q.size()); end
    n_chk++; if (got_q.size() > 0 && got_q[0] !== 16'h4321) begin n_fail++; $display("FAIL bw0_value: got %h want 4321", got_q[0]); end
    in_words = '{16'hAAAA, 16'h5555, 16'h0000};
    run_frame(31, 1, 2, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 2 || got_q.size() !== 2) begin n_fail++; $display("FAIL bw31_frame: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 2 2", viol, timed_out, used, got_q.size()); end
    n_chk++; if (got_q.size() == 2 && (got_q[0] !== 16'hAAAA || got_q[1] !== 16'h5555)) begin n_fail++; $display("FAIL bw31_values: got %h %h want aaaa 5555", got_q[0], got_q[1]); end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    int w = 0;
    @(negedge clk);
    cfg_bitwidth = 5'd4;
    cfg_signed = 1'b0;
    cfg_count = 32'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int g = 0; g < 100 && k < 3; g++) begin
      if (trm_valid) k++;
      rcv_valid = 1'b1;
      rcv_data = w == 0 ? 16'h4321 : 16'h8765;
      trm_ready = 1'b1;
      if (rcv_ready) w++;
      @(negedge clk);
    end
    n_chk++; if (k !== 3) begin n_fail++; $display("FAIL rst_mid_progress: got %0d values want 3", k); end
    rst = 1'b1;
    #1;
    n_chk++; if ({rcv_ready, trm_valid, trm_last, busy, done} !== 5'b0 || trm_data !== 16'h0) begin n_fail++; $display("FAIL rst_mid_outputs: rdy=%b vld=%b last=%b busy=%b done=%b data=%h want all 0", rcv_ready, trm_valid, trm_last, busy, done, trm_data); end
    rcv_valid = 1'b0;
    trm_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    in_words = '{16'h4321, 16'h8765, 16'h0000};
    run_frame(4, 0, 8, 100, 100, 0, 0, -1);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 2 || got_q.size() !== 8) begin n_fail++; $display("FAIL rst_mid_refresh: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 2 8", viol, timed_out, used, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_chk++; if (got_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL rst_mid_value[%0d]: got %h want %h", i, got_q[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_start_while_busy();
    in_words = '{16'h4321, 16'h8765, 16'hEEEE};
    run_frame(4, 0, 8, 100, 100, 0, 0, 2);
    n_chk++; if (viol !== 0 || timed_out !== 0 || used !== 2 || got_q.size() !== 8) begin n_fail++; $display("FAIL start_busy_frame: violations=%0d timeout=%0d words=%0d values=%0d want 0 0 2 8", viol, timed_out, used, got_q.size()); end
    for (int i = 0; i < got_q.size() && i < 8; i++) begin
      n_chk++; if (got_q[i] !== 16'(i + 1)) begin n_fail++; $display("FAIL start_busy_value[%0d]: got %h want %h", i, got_q[i], 16'(i + 1)); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 20; f++) begin
      int bwc = $urandom_range(0, 20);
      int bwe = (bwc == 0 || bwc > 16) ? 16 : bwc;
      bit sg = 1'($urandom_range(1));
      int cnt = $urandom_range(0, 24);
      int needed = (cnt * bwe + 15) / 16;
      in_words.delete();
      for (int i = 0; i < needed + 2; i++) in_words.push_back(16'($urandom));
      model(bwe, sg, cnt);
      run_frame(bwc, sg, cnt, $urandom_range(40, 100), $urandom_range(40, 100), 0, 0, -1);
      n_chk++; if (viol !== 0 || timed_out !== 0 || used !== needed || got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL random%0d_frame: violations=%0d timeout=%0d words=%0d/%0d values=%0d/%0d", f, viol, timed_out, used, needed, got_q.size(), exp_q.size()); end
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_chk++; if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random%0d_value[%0d]: bw=%0d sgn=%0d got %h want %h", f, i, bwe, sg, got_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    rcv_valid = 1'b0;
    rcv_data = '0;
    trm_ready = 1'b0;
    cfg_bitwidth = '0;
    cfg_signed = 1'b0;
    cfg_count = '0;
    test_reset();
    test_basic();
    test_straddle_signed();
    test_pad_discard();
    test_backpressure();
    test_edge();
    test_reset_mid();
    test_start_while_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
